// File: rtl/float_sub_seq.sv
// Sequential half-precision subtractor o = floatA - floatB (implicit leading 1, truncating).
// Aligns and normalises one bit per cycle behind a valid/ready handshake.
module float_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] o,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t      r_state;
    logic [10:0] r_fa;
    logic [10:0] r_fb;
    logic        r_sa;
    logic        r_sb;
    logic        r_shift_a;
    logic        r_sign;
    logic [5:0]  r_e;
    logic [9:0]  r_f;
    logic [3:0]  r_cnt;
    logic [15:0] r_o;
    logic        r_out_valid;
    logic        r_in_ready;

    logic [4:0]  w_ea;
    logic [4:0]  w_eb;
    logic [4:0]  w_d;
    logic [11:0] w_sum;
    logic        w_a_ge;
    logic [10:0] w_diff;
    logic [10:0] w_add_f;
    logic [5:0]  w_add_e;
    logic        w_add_sign;
    logic        w_add_sat;
    logic        w_add_zero;
    logic [10:0] w_norm_f;
    logic [5:0]  w_norm_e;

    assign w_ea   = floatA[14:10];
    assign w_eb   = floatB[14:10];
    assign w_d    = (w_ea >= w_eb) ? (w_ea - w_eb) : (w_eb - w_ea);

    assign w_sum  = {1'b0, r_fa} + {1'b0, r_fb};
    assign w_a_ge = (r_fa >= r_fb);
    assign w_diff = w_a_ge ? (r_fa - r_fb) : (r_fb - r_fa);

    always_comb begin
        w_add_sign = r_sa;
        w_add_f    = w_sum[10:0];
        w_add_e    = r_e;
        w_add_sat  = 1'b0;
        w_add_zero = 1'b0;
        if (r_sa == r_sb) begin
            if (w_sum[11]) begin
                w_add_f   = w_sum[11:1];
                w_add_e   = r_e + 6'd1;
                w_add_sat = (r_e == 6'd31);
            end
        end else begin
            w_add_sign = w_a_ge ? r_sa : r_sb;
            w_add_f    = w_diff;
            w_add_zero = (w_diff == '0);
        end
    end

    // In NORM the fraction's bit 10 is known to be 0, so only bits 9:0 are kept.
    assign w_norm_f = {r_f, 1'b0};
    assign w_norm_e = r_e - 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fa        <= '0;
            r_fb        <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_shift_a   <= 1'b0;
            r_sign      <= 1'b0;
            r_e         <= '0;
            r_f         <= '0;
            r_cnt       <= '0;
            r_o         <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_fa       <= {1'b1, floatA[9:0]};
                        r_fb       <= {1'b1, floatB[9:0]};
                        r_sa       <= floatA[15];
                        r_sb       <= ~floatB[15];
                        r_shift_a  <= (w_ea < w_eb);
                        r_e        <= {1'b0, (w_ea >= w_eb) ? w_ea : w_eb};
                        r_cnt      <= (w_d > 5'd12) ? 4'd12 : w_d[3:0];
                        r_in_ready <= 1'b0;
                        r_state    <= (w_d != '0) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    if (r_shift_a) begin
                        r_fa <= r_fa >> 1;
                    end else begin
                        r_fb <= r_fb >> 1;
                    end
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (w_add_sat) begin
                        r_o         <= {w_add_sign, 5'h1F, 10'h3FF};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_add_zero) begin
                        r_o         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_add_f[10]) begin
                        r_o         <= {w_add_sign, w_add_e[4:0], w_add_f[9:0]};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_f     <= w_add_f[9:0];
                        r_e     <= w_add_e;
                        r_sign  <= w_add_sign;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_e == '0) begin
                        r_o         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_norm_f[10]) begin
                        r_o         <= {r_sign, w_norm_e[4:0], w_norm_f[9:0]};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_f <= w_norm_f[9:0];
                        r_e <= w_norm_e;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o         = r_o;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_float_sub_seq.sv
// Self-checking bench for float_sub_seq: directed cases plus random operands
// against an integer-arithmetic reference of the subtraction rules.
module tb_float_sub_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] floatA;
    logic [15:0] floatB;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] o;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    float_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .floatA    (floatA),
        .floatB    (floatB),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Signed-integer view: align by truncating shift, add signed magnitudes, renormalise.
    task automatic ref_sub(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output int lat);
        int ea, eb, ma, mb, d, sh, e, s, mag, n;
        logic sgn;
        logic [31:0] ev, mv;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        d  = (ea > eb) ? ea - eb : eb - ea;
        sh = (d > 12) ? 12 : d;
        if (ea < eb) ma = ma >> sh;
        else         mb = mb >> sh;
        e   = (ea > eb) ? ea : eb;
        s   = (a[15] ? -ma : ma) + (b[15] ? mb : -mb);
        lat = 1 + sh;
        n   = 0;
        res = 16'h0000;
        if (s == 0) return;
        sgn = (s < 0);
        mag = (s < 0) ? -s : s;
        if (mag >= 2048) begin
            mag = mag >> 1;
            e   = e + 1;
            if (e > 31) begin
                res = {sgn, 15'h7FFF};
                return;
            end
        end
        while (mag < 1024) begin
            mag = mag << 1;
            e   = e - 1;
            n++;
            if (e < 0) begin
                lat = lat + n;
                return;
            end
        end
        lat = lat + n;
        ev  = e;
        mv  = mag;
        res = {sgn, ev[4:0], mv[9:0]};
    endtask

    // Called #1 after a rising edge; hold = cycles to keep out_ready low after out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] exp_o;
        int          exp_lat;
        int          lat;
        int          w;
        ref_sub(a, b, exp_o, exp_lat);
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("idle_ready", in_ready, 1);
        floatA   = a;
        floatB   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        floatA   = 16'($urandom);
        floatB   = 16'($urandom);
        lat = 0;
        if (exp_lat > 0) chk("busy_ready", in_ready, 0);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid", out_valid, 1);
        chk("latency", lat, exp_lat);
        chk("result", o, exp_o);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            floatA   = 16'($urandom);
            floatB   = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_o", o, exp_o);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drop_valid", out_valid, 0);
        chk("back_ready", in_ready, 1);
    endtask

    initial begin
        logic [15:0] a, b;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        floatA    = '0;
        floatB    = '0;
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_o", o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h4200, 16'h3C00, 0);
        run_op(16'h3C00, 16'h3C00, 0);
        run_op(16'h3C00, 16'hBC00, 0);
        run_op(16'h3C00, 16'h3BFF, 0);
        run_op(16'h0400, 16'h03FF, 0);
        run_op(16'h7C00, 16'hFC00, 0);
        run_op(16'hFC00, 16'h7C00, 0);
        run_op(16'h7800, 16'h3C00, 0);
        run_op(16'h3C00, 16'h7800, 0);
        run_op(16'h4200, 16'h3C00, 5);

        // Abort mid-ALIGN with an asynchronous reset.
        floatA   = 16'h7800;
        floatB   = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_o", o, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h4200, 16'h3C00, 0);

        for (int k = 0; k < 400; k++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom);
                1: b = {1'($urandom), 5'(a[14:10] + 5'($urandom_range(0, 2))), 10'($urandom)};
                2: b = a ^ {1'($urandom), 5'd0, 10'($urandom_range(0, 7))};
                default: b = a ^ {1'b0, 5'($urandom_range(0, 1)), 10'($urandom)};
            endcase
            run_op(a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
